first_event_detector: RTL
=========================

FIRST_EVENT_DETECTOR -- requirements
Module: first_event_detector

Interface
REQ-001 Parameter N_CH, default 8: number of input channels, legal range 2..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser depth per channel, legal range 0..3; 0 means inputs are already synchronous.
REQ-003 Parameter TIMEOUT_CYC, default 255: length of the armed window in clk cycles; 0 disables the timeout.
REQ-004 Parameter TIE_MODE, default 0: 0 means the lowest index wins a simultaneous edge; 1 means all simultaneous edges are reported and tie is flagged.
REQ-005 clk  input  1  system clock; all logic on the rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 sig  input  N_CH  channel inputs, possibly asynchronous.
REQ-008 arm  input  1  single-cycle pulse that opens a detection window.
REQ-009 clear  input  1  single-cycle pulse that returns the block to IDLE.
REQ-010 y  output  N_CH  winning channel mask; one-hot unless tie=1.
REQ-011 winner_idx  output  $clog2(N_CH)  index of the lowest set bit of y.
REQ-012 valid  output  1  a winner is latched.
REQ-013 tie  output  1  more than one channel rose in the deciding cycle (TIE_MODE=1 only).
REQ-014 timeout  output  1  the window expired with no edge.
REQ-015 busy  output  1  the window is open (ARMED).

Function
REQ-016 Each channel SHALL pass through SYNC_STAGES flops; edge_det[i] SHALL be sync[i] AND NOT sync_d[i].
REQ-017 A channel that is already high when arm arrives SHALL NOT count; only a later 0->1 transition counts.
REQ-018 The FSM SHALL have four states: IDLE, ARMED, LOCKED, EXPIRED.
REQ-019 IDLE->ARMED on arm; the timeout counter SHALL load 0.
REQ-020 ARMED->LOCKED in the cycle where edge_det is non-zero; y, winner_idx, valid and tie SHALL be registered one cycle later.
REQ-021 Total latency from a sig rise to valid high SHALL be SYNC_STAGES+2 cycles.
REQ-022 With TIE_MODE=0, y SHALL be the lowest-index set bit of edge_det and tie SHALL stay 0.
REQ-023 With TIE_MODE=1, y SHALL equal edge_det; tie SHALL be 1 when popcount(edge_det) is greater than 1.
REQ-024 In ARMED with TIMEOUT_CYC>0, the counter SHALL increment each cycle; on reaching TIMEOUT_CYC-1 with no edge, the FSM SHALL go to EXPIRED and timeout SHALL assert on the next cycle.
REQ-025 An edge in the same cycle as counter expiry SHALL win: the FSM goes to LOCKED, not EXPIRED.
REQ-026 In LOCKED and EXPIRED, all outputs SHALL hold; further edges and arm SHALL be ignored.
REQ-027 arm in ARMED SHALL restart the counter and SHALL NOT change the state.
REQ-028 clear in any state SHALL go to IDLE and zero y, winner_idx, valid, tie and timeout on the next cycle.
REQ-029 When clear and arm arrive in the same cycle, clear SHALL win and arm SHALL be dropped.
REQ-030 busy SHALL be 1 exactly when the state is ARMED.
REQ-031 The counter width SHALL be $clog2(TIMEOUT_CYC+1) and the counter SHALL never wrap.

Reset
REQ-032 While rst is high, the state SHALL be IDLE, all synchroniser and edge flops SHALL be 0, the counter SHALL be 0, and every output SHALL be 0.
REQ-033 rst asserted mid-window SHALL abort the window immediately; after release, the block SHALL stay in IDLE until a new arm.
REQ-034 Because the edge flops reset to 0, a channel that is high at reset release SHALL produce an edge after SYNC_STAGES cycles, and that edge SHALL be ignored unless the FSM is in ARMED.

Structure
REQ-035 A shared package fed_pkg SHALL hold the state enum fed_state_t and the default parameter constants.
REQ-036 One sub-module, fed_sync_edge (N_CH-wide synchroniser plus rising-edge detector), SHALL be instantiated once.
REQ-037 The priority encoder and popcount SHALL be inline functions in fed_pkg.

Verification (N_CH=8, SYNC_STAGES=2, TIMEOUT_CYC=16)
REQ-038 arm; 5 cycles later sig[5] rises -> valid=1 four cycles after the rise, y=8'h20, winner_idx=5, busy=0.
REQ-039 TIE_MODE=0: sig[6] and sig[2] rise in the same cycle -> y=8'h04, winner_idx=2, tie=0. TIE_MODE=1: same stimulus -> y=8'h44, winner_idx=2, tie=1.
REQ-040 arm with no edges -> timeout=1 at cycle 17 after arm, valid=0; a later sig rise leaves the outputs unchanged.
REQ-041 sig[0] held high before arm, then sig[3] rises -> y=8'h08; sig[0] is not reported.
REQ-042 sig[1] edge_det coincides with counter expiry -> valid=1, y=8'h02, timeout=0.
REQ-043 rst pulse while ARMED, then clear+arm in the same cycle from LOCKED -> all outputs 0 and the state is IDLE; busy stays 0.

Source files
------------

// File: rtl/fed_pkg.sv
// ---------------------------------------------------------------------------
// fed_pkg -- shared definitions for the first-event detector.
//   * fed_state_t      : detector FSM states
//   * FED_*_DEF        : default parameter values
//   * fed_lowest_onehot: isolate the lowest set bit of a 32-bit vector
//   * fed_lowest_idx   : index of the lowest set bit (0 when none is set)
//   * fed_popcount     : number of set bits
// Channel vectors of up to 32 bits are zero-extended into the helpers.
// ---------------------------------------------------------------------------
package fed_pkg;

  localparam int FED_N_CH_DEF        = 8;
  localparam int FED_SYNC_STAGES_DEF = 2;
  localparam int FED_TIMEOUT_CYC_DEF = 255;
  localparam int FED_TIE_MODE_DEF    = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    LOCKED  = 2'd2,
    EXPIRED = 2'd3
  } fed_state_t;

  // Two's-complement trick: v & -v keeps only the lowest set bit.
  function automatic logic [31:0] fed_lowest_onehot(input logic [31:0] v);
    return v & (~v + 32'd1);
  endfunction

  function automatic logic [4:0] fed_lowest_idx(input logic [31:0] v);
    logic [4:0] idx;
    idx = '0;
    // Scan downwards so the last hit (the lowest index) is the one kept.
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  function automatic logic [5:0] fed_popcount(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/fed_sync_edge.sv
// ---------------------------------------------------------------------------
// fed_sync_edge -- per-channel synchroniser followed by a rising-edge detector.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   sig      in   N_CH possibly asynchronous channel inputs
//   edge_det out  N_CH one-cycle pulses, high when a synchronised channel rose
// SYNC_STAGES = 0 bypasses the synchroniser (inputs already synchronous).
// ---------------------------------------------------------------------------
module fed_sync_edge
  import fed_pkg::*;
#(
  parameter int N_CH        = FED_N_CH_DEF,
  parameter int SYNC_STAGES = FED_SYNC_STAGES_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] sig,
  output logic [N_CH-1:0] edge_det
);

  logic [N_CH-1:0] sync;
  logic [N_CH-1:0] sync_prev_d;
  logic [N_CH-1:0] sync_prev_q;

  if (SYNC_STAGES == 0) begin : g_bypass
    assign sync = sig;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0][N_CH-1:0] stage_d;
    logic [SYNC_STAGES-1:0][N_CH-1:0] stage_q;

    always_comb begin
      stage_d[0] = sig;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    // NOTE: the synchroniser chain is reset like any other state; a stale
    // level left over from before reset would otherwise look like an edge.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) stage_q <= '0;
      else     stage_q <= stage_d;
    end

    assign sync = stage_q[SYNC_STAGES-1];
  end

  assign sync_prev_d = sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_prev_q <= '0;
    else     sync_prev_q <= sync_prev_d;
  end

  assign edge_det = sync & ~sync_prev_q;

endmodule

// File: rtl/first_event_detector.sv
// ---------------------------------------------------------------------------
// first_event_detector -- reports which channel rises first after arm.
// Ports:
//   clk        in   system clock (rising edge)
//   rst        in   asynchronous active-high reset
//   sig        in   N_CH channel inputs, possibly asynchronous
//   arm        in   pulse: open a detection window (IDLE -> ARMED)
//   clear      in   pulse: return to IDLE and zero all results
//   y          out  winning channel mask
//   winner_idx out  index of the lowest set bit of y
//   valid      out  a winner is latched
//   tie        out  several channels rose in the deciding cycle (TIE_MODE=1)
//   timeout    out  the window expired with no edge
//   busy       out  window open (state ARMED)
// Legal parameters: N_CH 2..32, SYNC_STAGES 0..3, TIMEOUT_CYC 0 = no timeout.
// Latency from a channel rise to valid is SYNC_STAGES+2 cycles: the FSM locks
// on edge_det, and the result registers load one cycle later.
// ---------------------------------------------------------------------------
module first_event_detector
  import fed_pkg::*;
#(
  parameter int N_CH        = FED_N_CH_DEF,
  parameter int SYNC_STAGES = FED_SYNC_STAGES_DEF,
  parameter int TIMEOUT_CYC = FED_TIMEOUT_CYC_DEF,
  parameter int TIE_MODE    = FED_TIE_MODE_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         sig,
  input  logic                    arm,
  input  logic                    clear,
  output logic [N_CH-1:0]         y,
  output logic [$clog2(N_CH)-1:0] winner_idx,
  output logic                    valid,
  output logic                    tie,
  output logic                    timeout,
  output logic                    busy
);

  localparam int IDX_W   = $clog2(N_CH);
  localparam int CNT_W   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int LAST_I  = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_I);

  logic [N_CH-1:0] edge_det;
  logic [31:0]     edge_ext;

  fed_state_t       state_d,   state_q;
  logic [CNT_W-1:0] cnt_d,     cnt_q;
  logic [N_CH-1:0]  cap_y_d,   cap_y_q;
  logic             cap_tie_d, cap_tie_q;
  logic [N_CH-1:0]  y_d,       y_q;
  logic [IDX_W-1:0] idx_d,     idx_q;
  logic             valid_d,   valid_q;
  logic             tie_d,     tie_q;
  logic             timeout_d, timeout_q;

  fed_sync_edge #(
    .N_CH        (N_CH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk      (clk),
    .rst      (rst),
    .sig      (sig),
    .edge_det (edge_det)
  );

  assign edge_ext = 32'(edge_det);

  always_comb begin
    // NOTE: every _d signal gets its hold value first, so no path through the
    // case below can leave one unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    cap_y_d   = cap_y_q;
    cap_tie_d = cap_tie_q;
    y_d       = y_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    tie_d     = tie_q;
    timeout_d = timeout_q;

    if (clear) begin
      // clear beats everything, including an arm in the same cycle.
      state_d   = IDLE;
      cnt_d     = '0;
      cap_y_d   = '0;
      cap_tie_d = 1'b0;
      y_d       = '0;
      idx_d     = '0;
      valid_d   = 1'b0;
      tie_d     = 1'b0;
      timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (arm) begin
            state_d = ARMED;
            cnt_d   = '0;
          end
        end
        ARMED: begin
          // An edge wins over a simultaneous expiry or re-arm.
          if (|edge_det) begin
            state_d   = LOCKED;
            cap_y_d   = (TIE_MODE != 0) ? edge_det
                                        : N_CH'(fed_lowest_onehot(edge_ext));
            cap_tie_d = (TIE_MODE != 0) && (fed_popcount(edge_ext) > 6'd1);
          end else if (arm) begin
            cnt_d = '0;
          end else if (TIMEOUT_CYC > 0) begin
            // Stop at the last count instead of incrementing: never wraps.
            if (cnt_q == CNT_LAST) state_d = EXPIRED;
            else                   cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        LOCKED: begin
          y_d     = cap_y_q;
          idx_d   = IDX_W'(fed_lowest_idx(32'(cap_y_q)));
          valid_d = 1'b1;
          tie_d   = cap_tie_q;
        end
        EXPIRED: begin
          timeout_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // all flops sample the values from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cap_y_q   <= '0;
      cap_tie_q <= 1'b0;
      y_q       <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      tie_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cap_y_q   <= cap_y_d;
      cap_tie_q <= cap_tie_d;
      y_q       <= y_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      tie_q     <= tie_d;
      timeout_q <= timeout_d;
    end
  end

  assign y          = y_q;
  assign winner_idx = idx_q;
  assign valid      = valid_q;
  assign tie        = tie_q;
  assign timeout    = timeout_q;
  assign busy       = (state_q == ARMED);

endmodule
